// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared constants and types for the sequential binary32 add/sub unit
// Contents: default field widths, all-ones exponent, quiet-NaN pattern,
// FSM state codes and the operand class enum.
package fp_pkg;

    localparam int EXP_W_DEF = 8;
    localparam int MAN_W_DEF = 23;

    localparam logic [EXP_W_DEF-1:0] EXP_MAX = '1;
    localparam logic [31:0]          QNAN    = 32'h7FC0_0000;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_ALIGN = 3'd1;
    localparam state_t ST_ADD   = 3'd2;
    localparam state_t ST_NORM  = 3'd3;
    localparam state_t ST_PACK  = 3'd4;
    localparam state_t ST_DONE  = 3'd5;

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_NORMAL,
        CLS_INF,
        CLS_NAN
    } op_class_t;

endpackage

// File: rtl/fp_unpack.sv
// rtl/fp_unpack.sv - combinational split of a packed float into fields and class
// Ports: word (packed operand) -> sign, exp_f (biased exponent),
// man (fraction with hidden bit; zero for zero/denormal), cls (operand class).
module fp_unpack
    import fp_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF
) (
    input  logic [EXP_W+MAN_W:0] word,
    output logic                 sign,
    output logic [EXP_W-1:0]     exp_f,
    output logic [MAN_W:0]       man,
    output op_class_t            cls
);

    logic [MAN_W-1:0] frac;

    assign sign  = word[EXP_W+MAN_W];
    assign exp_f = word[EXP_W+MAN_W-1:MAN_W];
    assign frac  = word[MAN_W-1:0];

    always_comb begin
        cls = CLS_NORMAL;
        man = {1'b1, frac};
        if (exp_f == '0) begin
            // denormals are flushed: treated exactly like zero
            cls = CLS_ZERO;
            man = '0;
        end else if (exp_f == '1) begin
            cls = (frac == '0) ? CLS_INF : CLS_NAN;
        end
    end

endmodule

// File: rtl/fp_addsub_seq.sv
// rtl/fp_addsub_seq.sv - multi-cycle binary32 add/subtract with valid/ready handshakes
// Ports: clk, rst_n (async active-low); in_valid/in_ready, a, b, op_sub (1: a-b);
// out_valid/out_ready, result. Normalisation shifts left one bit per cycle.
// Build option: FP_ADDSUB_RNE_EN adds guard/round/sticky bits and round-to-nearest-even;
// without it results are truncated.
module fp_addsub_seq
    import fp_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    input  logic                 op_sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] result
);

    localparam int W = 1 + EXP_W + MAN_W;
`ifdef FP_ADDSUB_RNE_EN
    localparam int GW = 3;
`else
    localparam int GW = 0;
`endif
    // aligned mantissa: hidden bit, fraction, then GW extra low bits
    localparam int MW = MAN_W + 1 + GW;
    localparam logic [EXP_W-1:0] EMAX   = '1;
    localparam logic [W-1:0]     QNAN_W = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

    state_t           state;
    logic [W-1:0]     a_q, b_q, spec_q;
    logic             special, zero_res, sign_x, sign_y, sign_res;
    logic [EXP_W-1:0] exp_res;
    logic [MW-1:0]    man_x, man_y;
    logic [MW:0]      sum;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W:0]   ma, mb;
    op_class_t        ca, cb;

    fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_a (
        .word(a_q), .sign(sa), .exp_f(ea), .man(ma), .cls(ca)
    );
    fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_b (
        .word(b_q), .sign(sb), .exp_f(eb), .man(mb), .cls(cb)
    );

    logic             a_big, is_special;
    logic [EXP_W-1:0] diff;
    logic [MW-1:0]    small_ext, aligned;
    logic [W-1:0]     spec_word;

    always_comb begin
        a_big     = (ea >= eb);
        diff      = a_big ? (ea - eb) : (eb - ea);
        small_ext = MW'(a_big ? mb : ma) << GW;
        if (diff >= EXP_W'(MAN_W + 3)) aligned = '0;
        else                           aligned = small_ext >> diff;
`ifdef FP_ADDSUB_RNE_EN
        // anything shifted past the round bit collapses into sticky; the smaller
        // operand is a normal here, so a huge shift always loses a nonzero value
        if (diff >= EXP_W'(MAN_W + 3))
            aligned[0] = 1'b1;
        else if ((small_ext & ~({MW{1'b1}} << diff)) != '0)
            aligned[0] = 1'b1;
`endif

        is_special = 1'b1;
        spec_word  = '0;
        if (ca == CLS_NAN || cb == CLS_NAN || (ca == CLS_INF && cb == CLS_INF && sa != sb))
            spec_word = QNAN_W;
        else if (ca == CLS_INF)                  spec_word = a_q;
        else if (cb == CLS_INF)                  spec_word = b_q;
        else if (ca == CLS_ZERO && cb == CLS_ZERO) spec_word = {sa & sb, {(W-1){1'b0}}};
        else if (ca == CLS_ZERO)                 spec_word = b_q;
        else if (cb == CLS_ZERO)                 spec_word = a_q;
        else                                     is_special = 1'b0;
    end

    logic             round_up, frac_cy;
    logic [MAN_W-1:0] frac_r;
    logic [EXP_W:0]   exp_n;
    logic [W-1:0]     pack_word;

    always_comb begin
        round_up = 1'b0;
`ifdef FP_ADDSUB_RNE_EN
        // guard set and (round | sticky | lsb odd): nearest, ties to even
        round_up = sum[2] & (sum[1] | sum[0] | sum[3]);
`endif
        // a carry out of the fraction means 1.11..1 rounded to 10.0: frac wraps to 0
        {frac_cy, frac_r} = {1'b0, sum[MW-2:GW]} + (MAN_W+1)'(round_up);
        exp_n = {1'b0, exp_res} + (EXP_W+1)'(frac_cy);
        if (special)                       pack_word = spec_q;
        else if (zero_res)                 pack_word = {sign_res, {(W-1){1'b0}}};
        else if (exp_n >= {1'b0, EMAX})    pack_word = {sign_res, EMAX, {MAN_W{1'b0}}};
        else                               pack_word = {sign_res, exp_n[EXP_W-1:0], frac_r};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            spec_q   <= '0;
            special  <= 1'b0;
            zero_res <= 1'b0;
            sign_x   <= 1'b0;
            sign_y   <= 1'b0;
            sign_res <= 1'b0;
            exp_res  <= '0;
            man_x    <= '0;
            man_y    <= '0;
            sum      <= '0;
            result   <= '0;
        end else begin
            case (state)
                ST_IDLE: if (in_valid) begin
                    a_q   <= a;
                    b_q   <= b ^ {op_sub, {(W-1){1'b0}}};
                    state <= ST_ALIGN;
                end
                ST_ALIGN: begin
                    special  <= is_special;
                    spec_q   <= spec_word;
                    zero_res <= 1'b0;
                    exp_res  <= a_big ? ea : eb;
                    man_x    <= MW'(a_big ? ma : mb) << GW;
                    man_y    <= aligned;
                    sign_x   <= a_big ? sa : sb;
                    sign_y   <= a_big ? sb : sa;
                    state    <= is_special ? ST_PACK : ST_ADD;
                end
                ST_ADD: begin
                    // man_x carries the larger exponent, so man_y can only exceed
                    // it when the exponents are equal
                    if (sign_x == sign_y) begin
                        sum      <= {1'b0, man_x} + {1'b0, man_y};
                        sign_res <= sign_x;
                    end else if (man_x >= man_y) begin
                        sum      <= {1'b0, man_x - man_y};
                        sign_res <= sign_x;
                    end else begin
                        sum      <= {1'b0, man_y - man_x};
                        sign_res <= sign_y;
                    end
                    state <= ST_NORM;
                end
                ST_NORM: begin
                    if (sum == '0) begin
                        sign_res <= 1'b0;
                        zero_res <= 1'b1;
                        state    <= ST_PACK;
                    end else if (sum[MW]) begin
`ifdef FP_ADDSUB_RNE_EN
                        sum <= {1'b0, sum[MW:2], sum[1] | sum[0]};
`else
                        sum <= sum >> 1;
`endif
                        exp_res <= exp_res + 1'b1;
                        state   <= ST_PACK;
                    end else if (sum[MW-1]) begin
                        state <= ST_PACK;
                    end else if (exp_res == EXP_W'(1)) begin
                        zero_res <= 1'b1;
                        state    <= ST_PACK;
                    end else begin
                        sum     <= sum << 1;
                        exp_res <= exp_res - 1'b1;
                    end
                end
                ST_PACK: begin
                    result <= pack_word;
                    state  <= ST_DONE;
                end
                ST_DONE: if (out_ready) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_addsub_seq.sv
// tb/tb_fp_addsub_seq.sv - self-checking bench for fp_addsub_seq with a behavioural reference
module tb_fp_addsub_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        op_sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fp_addsub_seq dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op_sub(op_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Value-level model: flush-to-zero inputs, exact signed sum of the aligned
    // (truncated) magnitudes, then normalise with truncation and flush below exp 1.
    function automatic void ref_model(input logic [31:0] ia, input logic [31:0] ib,
                                      input logic op, output logic [31:0] r, output int lat);
        logic [31:0] bv;
        int     ea, eb, ex, e, k;
        longint ma, mb, mx, my, v, m;
        logic   sa, sb, s, nan_a, nan_b, inf_a, inf_b;
        bv = ib ^ {op, 31'b0};
        sa = ia[31]; sb = bv[31];
        ea = int'(ia[30:23]); eb = int'(bv[30:23]);
        nan_a = (ea == 255) && (ia[22:0] != 0);
        nan_b = (eb == 255) && (bv[22:0] != 0);
        inf_a = (ea == 255) && !nan_a;
        inf_b = (eb == 255) && !nan_b;
        lat = 2;
        if (nan_a || nan_b)            r = 32'h7FC00000;
        else if (inf_a && inf_b)       r = (sa != sb) ? 32'h7FC00000 : ia;
        else if (inf_a)                r = ia;
        else if (inf_b)                r = bv;
        else if (ea == 0 && eb == 0)   r = {sa & sb, 31'b0};
        else if (ea == 0)              r = bv;
        else if (eb == 0)              r = ia;
        else begin
            ma = longint'({1'b1, ia[22:0]});
            mb = longint'({1'b1, bv[22:0]});
            if (ea >= eb) begin ex = ea; mx = ma; my = mb >>> (ea - eb); end
            else          begin ex = eb; mx = mb; my = ma >>> (eb - ea); end
            if (ea >= eb) v = (sa ? -mx : mx) + (sb ? -my : my);
            else          v = (sb ? -mx : mx) + (sa ? -my : my);
            k = 0;
            if (v == 0) r = 32'h0;
            else begin
                s = (v < 0);
                m = s ? -v : v;
                e = ex;
                if (m >= (64'sd1 << 24)) begin
                    m = m >>> 1;
                    e = e + 1;
                end
                while (m < (64'sd1 << 23) && e > 0) begin
                    if (e == 1) e = 0;
                    else begin m = m <<< 1; e = e - 1; k++; end
                end
                if (e == 0)        r = {s, 31'b0};
                else if (e >= 255) r = {s, 8'hFF, 23'b0};
                else               r = {s, 8'(e), m[22:0]};
            end
            lat = 4 + k;
        end
    endfunction

    task automatic run_op(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                          input logic op, input logic [31:0] exp_r, input int exp_lat);
        int lat;
        chk({tag, ".in_ready"}, {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1; a = ia; b = ib; op_sub = op;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, ".result"}, result, exp_r);
        chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        if (out_ready) begin
            @(posedge clk); #1;
            chk({tag, ".drop"}, {31'b0, out_valid}, 32'd0);
        end
    endtask

    initial begin
        logic [31:0] er, ra, rb;
        logic        ro;
        int          el;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst.out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst.result", result, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("one_plus_one", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4);
        run_op("sub_k2",       32'h3FC00000, 32'h3FA00000, 1'b1, 32'h3E800000, 6);
        run_op("sub_cancel",   32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4);
        run_op("inf_minus_inf", 32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 2);
        run_op("inf_plus_one", 32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 2);
        run_op("zero_plus_x",  32'h00000000, 32'hC0400000, 1'b0, 32'hC0400000, 2);
        run_op("nan_in",       32'h7FC12345, 32'h3F800000, 1'b0, 32'h7FC00000, 2);
        run_op("neg_zeros",    32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 2);
        run_op("overflow",     32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4);
        run_op("align_flush",  32'h4B800000, 32'h3F800000, 1'b0, 32'h4B800000, 4);
        run_op("tiny_pos",     32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4);
        run_op("tiny_neg",     32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 4);
`ifdef FP_ADDSUB_RNE_EN
        run_op("round",        32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 4);
`else
        run_op("round",        32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800000, 4);
`endif

`ifndef FP_ADDSUB_RNE_EN
        // randomized operands, exponents often close so cancellation and shifts occur
        for (int i = 0; i < 60; i++) begin
            ra = $urandom;
            rb = $urandom;
            ro = 1'($urandom_range(0, 1));
            case (i % 4)
                0: rb[30:23] = ra[30:23];
                1: rb[30:23] = ra[30:23] - 8'($urandom_range(0, 3));
                2: rb[30:23] = ra[30:23] + 8'($urandom_range(0, 3));
                default: ;
            endcase
            if (i % 10 == 7) ra[30:23] = 8'hFF;
            if (i % 10 == 9) rb[30:23] = 8'h00;
            ref_model(ra, rb, ro, er, el);
            run_op($sformatf("rnd%0d", i), ra, rb, ro, er, el);
        end
`endif

        // backpressure: result held while out_ready is low
        out_ready = 1'b0;
        run_op("bp", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk($sformatf("bp.valid%0d", i), {31'b0, out_valid}, 32'd1);
            chk($sformatf("bp.result%0d", i), result, 32'h40000000);
            chk($sformatf("bp.in_ready%0d", i), {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp.release_valid", {31'b0, out_valid}, 32'd0);
        chk("bp.release_ready", {31'b0, in_ready}, 32'd1);

        // reset while normalising
        in_valid = 1'b1; a = 32'h3FC00000; b = 32'h3FA00000; op_sub = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst.out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst.result", result, 32'h0);
        chk("midrst.in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk($sformatf("midrst.quiet%0d", i), {31'b0, out_valid}, 32'd0);
        end
        run_op("after_rst", 32'h3FC00000, 32'h3FA00000, 1'b1, 32'h3E800000, 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_addsub_seq.md
Name: fp_addsub_seq

Overview:
- Multi-cycle IEEE-754 binary32 add/subtract unit with valid/ready handshakes on input and output.
- Complements the team's combinational subtractor. It provides the addition direction (op_sub=0) and a corrected subtraction (op_sub=1) as a registered, backpressure-aware datapath stage.
- Normalisation is iterative: one left shift per cycle.

Parameters:
- EXP_W, 8, exponent field width
- MAN_W, 23, stored fraction width (hidden bit is implicit)

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands and op_sub are valid
- in_ready  out  1  unit can accept; equals (state==IDLE)
- a  in  1+EXP_W+MAN_W  operand A
- b  in  1+EXP_W+MAN_W  operand B
- op_sub  in  1  1 computes a-b (b sign inverted at capture); 0 computes a+b
- out_valid  out  1  result is valid
- out_ready  in  1  consumer accepts result
- result  out  1+EXP_W+MAN_W  packed sum/difference

Behaviour:
- Reset (asynchronous, any state): state=IDLE, out_valid=0, result=0, in_ready=1, all datapath registers 0.
- States: IDLE, ALIGN, ADD, NORM, PACK, DONE.
- IDLE: on in_valid&in_ready, capture a, b^{op_sub<<31}, go to ALIGN.
- ALIGN: unpack operands; zero/denormal (exp==0) is treated as zero (flush).
  - Specials resolve here and go straight to PACK:
    - any NaN -> quiet NaN 0x7FC00000
    - +inf + -inf -> 0x7FC00000
    - single inf -> that inf
    - one zero -> the other operand
    - both zero -> +0, or -0 only if both effective signs are 1
  - Otherwise: larger exponent becomes exp_res; smaller mantissa is right-shifted by the difference. A difference >=MAN_W+3 yields 0. Go to ADD.
- ADD:
  - Equal signs: 25-bit sum, sign = shared sign.
  - Differing signs: larger magnitude minus smaller; sign = sign of the larger magnitude. Ties compare exponent first, then mantissa.
  - Go to NORM.
- NORM, evaluated once per cycle:
  - sum==0 -> +0, go to PACK.
  - carry bit set -> shift right 1, exp+1, go to PACK.
  - bit MAN_W set -> go to PACK.
  - else exp==1 -> flush to signed zero, go to PACK.
  - else shift left 1, exp-1, stay in NORM.
- PACK: exp reaching 2^EXP_W-1 -> ±inf (fraction 0). Register result, go to DONE.
- DONE: out_valid=1. result holds stable until out_ready. On handshake, go to IDLE next edge and drop out_valid. There is no same-cycle re-accept.
- Latency, accept edge to out_valid high:
  - normal path: 4+k edges, k = number of left shifts in NORM
  - special path: 2 edges
- Rounding: truncation (guard bits discarded).
- Reset mid-operation aborts with no output.

Optional Feature:
- FP_ADDSUB_RNE_EN defined: mantissa path carries guard/round/sticky bits.
  - ALIGN ORs shifted-out bits into sticky.
  - PACK applies round-to-nearest-even. Mantissa overflow from rounding increments exp and may produce inf.
  - PACK stays a single cycle, so latency is unchanged.
- Undefined: truncation, no GRS registers.

Decomposition:
- Shared package fp_pkg holds:
  - EXP_W/MAN_W defaults
  - EXP_MAX (all-ones exponent)
  - QNAN constant 0x7FC00000
  - state enum for this FSM
  - operand class enum (ZERO, NORMAL, INF, NAN)
- Sub-module fp_unpack (combinational): splits a word into sign/exp/mantissa-with-hidden-bit plus class. Instantiated twice in ALIGN.

Test Plan:
- 0x3F800000 + 0x3F800000, op_sub=0 -> 0x40000000; out_valid exactly 4 edges after accept.
- 0x3FC00000 - 0x3FA00000, op_sub=1 -> 0x3E800000; k=2, latency 6. Also 0x3F800000 - 0x3F800000 -> 0x00000000, latency 4.
- Specials:
  - 0x7F800000 + 0xFF800000 -> 0x7FC00000
  - 0x7F800000 + 0x3F800000 -> 0x7F800000
  - 0x00000000 + 0xC0400000 -> 0xC0400000
  - each with latency 2
- Overflow: 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000. Alignment flush: 0x4B800000 + 0x3F800000 -> 0x4B800000 in truncation mode.
- Rounding: 0x3F800000 + 0x33C00000 -> 0x3F800000 without FP_ADDSUB_RNE_EN; 0x3F800001 with it.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles: result and out_valid stable, in_ready=0.
  - Assert rst_n=0 while in NORM: out_valid=0, result=0, in_ready=1 immediately.
